// File: rtl/proc_seq_pkg.sv
// ============================================================================
//  Module      : proc_seq_pkg
//  Description : Shared widths, sequencer state encoding and processor opcodes
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package proc_seq_pkg;

    localparam int IW_DEFAULT = 12;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_t;

    // instruction[11:8] = opcode, [7:4] = Rx, [3:0] = Ry
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_MOVE = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;

endpackage

`default_nettype wire

// File: rtl/seq_prog_mem.sv
// ============================================================================
//  Module      : seq_prog_mem
//  Description : Program store, synchronous write / asynchronous read
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 28
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/proc_instr_sequencer.sv
// ============================================================================
//  Module      : proc_instr_sequencer
//  Description : Plays a loaded {instruction, data} program into the processor
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module proc_instr_sequencer
    import proc_seq_pkg::*;
#(
    parameter int IW          = IW_DEFAULT,
    parameter int DW          = DW_DEFAULT,
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_instr,
    input  logic [DW-1:0] load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    output logic [IW-1:0] instruction_F,
    output logic [DW-1:0] data,
    output logic          w,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    localparam int                c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [AW:0]       c_depth     = (AW + 1)'(DEPTH);

    seq_state_t          r_state;
    logic [AW:0]         r_len;
    logic [c_hold_w-1:0] r_hold;

    logic                w_idle;
    logic [AW-1:0]       w_rd_addr;
    logic [IW+DW-1:0]    w_rd_entry;
    logic [AW:0]         w_len_clamped;
    logic                w_last_entry;
    logic                w_end;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_len_clamped = (prog_len > c_depth) ? c_depth : prog_len;
    assign w_last_entry  = ({1'b0, pc} == (r_len - {{AW{1'b0}}, 1'b1}));
    assign w_end         = (r_state == ST_RUN) && !abort && !pause &&
                           (r_hold == c_hold_last) && w_last_entry;
    // In IDLE the only read needed is entry 0; in RUN it is the upcoming entry
    assign w_rd_addr     = (r_state == ST_RUN) ? (pc + AW'(1)) : '0;

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (IW + DW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (load_en && w_idle),
        .i_waddr (load_addr),
        .i_wdata ({load_instr, load_data}),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_hold        <= '0;
            instruction_F <= '0;
            data          <= '0;
            w             <= 1'b0;
            pc            <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!w_idle && (abort || w_end)) begin
                r_state       <= ST_IDLE;
                r_hold        <= '0;
                instruction_F <= '0;
                data          <= '0;
                w             <= 1'b0;
                pc            <= '0;
                busy          <= 1'b0;
                done          <= w_end;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_len <= w_len_clamped;
                            if (w_len_clamped == '0) begin
                                done <= 1'b1;
                            end else begin
                                r_state       <= ST_RUN;
                                r_hold        <= '0;
                                pc            <= '0;
                                instruction_F <= w_rd_entry[IW+DW-1:DW];
                                data          <= w_rd_entry[DW-1:0];
                                w             <= 1'b1;
                                busy          <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        // The cycle in which pause is sampled is not credited to the entry
                        if (pause) begin
                            r_state <= ST_PAUSE;
                            w       <= 1'b0;
                        end else if (r_hold == c_hold_last) begin
                            r_hold        <= '0;
                            pc            <= pc + AW'(1);
                            instruction_F <= w_rd_entry[IW+DW-1:DW];
                            data          <= w_rd_entry[DW-1:0];
                        end else begin
                            r_hold <= r_hold + c_hold_w'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause) begin
                            r_state <= ST_RUN;
                            w       <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_proc_instr_sequencer.sv
// ============================================================================
//  Module      : tb_proc_instr_sequencer
//  Description : Directed bench for proc_instr_sequencer (HOLD 1 and HOLD 3)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_proc_instr_sequencer;
    import proc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [11:0] load_instr = '0;
    logic [15:0] load_data = '0;
    logic [4:0]  prog_len = '0;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;

    logic [11:0] instr1, instr3;
    logic [15:0] data1, data3;
    logic        w1, w3, busy1, busy3, done1, done3;
    logic [3:0]  pc1, pc3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] exp_instr [16];
    logic [15:0] exp_data  [16];

    always #5 clk = ~clk;

    proc_instr_sequencer #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_instr(load_instr), .load_data(load_data), .prog_len(prog_len),
        .start(start1), .pause(pause), .abort(abort),
        .instruction_F(instr1), .data(data1), .w(w1), .pc(pc1),
        .busy(busy1), .done(done1)
    );

    proc_instr_sequencer #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_instr(load_instr), .load_data(load_data), .prog_len(prog_len),
        .start(start3), .pause(1'b0), .abort(abort),
        .instruction_F(instr3), .data(data3), .w(w3), .pc(pc3),
        .busy(busy3), .done(done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [11:0] ei, input logic [15:0] ed,
                        input logic ew, input logic [3:0] epc, input logic eb, input logic edn);
        chk({tag, ".instr"}, 32'(instr1), 32'(ei));
        chk({tag, ".data"},  32'(data1),  32'(ed));
        chk({tag, ".w"},     32'(w1),     32'(ew));
        chk({tag, ".pc"},    32'(pc1),    32'(epc));
        chk({tag, ".busy"},  32'(busy1),  32'(eb));
        chk({tag, ".done"},  32'(done1),  32'(edn));
    endtask

    initial begin
        exp_instr[0] = {OP_LOAD, 4'h0, 4'h0}; exp_data[0] = 16'd1;
        exp_instr[1] = {OP_MOVE, 4'h1, 4'h0}; exp_data[1] = 16'd1;
        exp_instr[2] = {OP_ADD,  4'h0, 4'h1}; exp_data[2] = 16'd1;
        exp_instr[3] = {OP_SUB,  4'h2, 4'h0}; exp_data[3] = 16'd2;
        for (int i = 4; i < 16; i++) begin
            exp_instr[i] = 12'h500 + 12'(i);
            exp_data[i]  = 16'(i * 3);
        end

        // Reset, with start held to confirm rst priority
        start1 = 1'b1;
        tick(); tick();
        rst = 1'b0; start1 = 1'b0;
        chk1("reset", '0, '0, 1'b0, '0, 1'b0, 1'b0);
        chk("reset.busy3", 32'(busy3), 32'd0);

        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_addr = 4'(i);
            load_instr = exp_instr[i]; load_data = exp_data[i];
            tick();
        end
        load_en = 1'b0;

        // Basic 4-entry playback, HOLD 1
        prog_len = 5'd4; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("play1[%0d]", k), exp_instr[k], exp_data[k], 1'b1, 4'(k), 1'b1, 1'b0);
            tick();
        end
        chk1("play1.end", '0, '0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        chk("play1.done_once", 32'(done1), 32'd0);

        // HOLD 3 playback: each entry for 3 cycles
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int h = 0; h < 3; h++) begin
                chk($sformatf("play3[%0d.%0d].instr", k, h), 32'(instr3), 32'(exp_instr[k]));
                chk($sformatf("play3[%0d.%0d].w", k, h), 32'(w3), 32'd1);
                chk($sformatf("play3[%0d.%0d].pc", k, h), 32'(pc3), 32'(k));
                tick();
            end
        end
        chk("play3.done", 32'(done3), 32'd1);
        chk("play3.w", 32'(w3), 32'd0);
        chk("play3.busy", 32'(busy3), 32'd0);
        tick();
        chk("play3.done_once", 32'(done3), 32'd0);

        // Pause for 3 cycles at pc=2; entry 2 is re-presented on resume
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        chk1("pause.pre", exp_instr[2], exp_data[2], 1'b1, 4'd2, 1'b1, 1'b0);
        pause = 1'b1;
        tick();
        chk1("pause.c1", exp_instr[2], exp_data[2], 1'b0, 4'd2, 1'b1, 1'b0);
        tick();
        chk1("pause.c2", exp_instr[2], exp_data[2], 1'b0, 4'd2, 1'b1, 1'b0);
        tick();
        chk1("pause.c3", exp_instr[2], exp_data[2], 1'b0, 4'd2, 1'b1, 1'b0);
        pause = 1'b0;
        tick();
        chk1("pause.resume", exp_instr[2], exp_data[2], 1'b1, 4'd2, 1'b1, 1'b0);
        tick();
        chk1("pause.next", exp_instr[3], exp_data[3], 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        chk1("pause.end", '0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Zero-length program
        prog_len = 5'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk1("len0", '0, '0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        chk1("len0.after", '0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Oversized length clamps to 16 entries
        prog_len = 5'd20; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("len20[%0d].instr", k), 32'(instr1), 32'(exp_instr[k]));
            chk($sformatf("len20[%0d].pc", k), 32'(pc1), 32'(k));
            chk($sformatf("len20[%0d].w", k), 32'(w1), 32'd1);
            tick();
        end
        chk1("len20.end", '0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Abort at pc=1, then replay from entry 0
        prog_len = 5'd4; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        chk("abort.pre_pc", 32'(pc1), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort", '0, '0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("abort.no_done", 32'(done1), 32'd0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk1("replay[0]", exp_instr[0], exp_data[0], 1'b1, 4'd0, 1'b1, 1'b0);
        tick();
        chk("replay.pc1", 32'(pc1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst_mid", '0, '0, 1'b0, '0, 1'b0, 1'b0);

        // load_en and start during playback are ignored
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        load_en = 1'b1; load_addr = 4'd3; load_instr = 12'h4FF; load_data = 16'hFFFF;
        start1 = 1'b1;
        tick();
        load_en = 1'b0; start1 = 1'b0;
        chk("busyload.pc1", 32'(pc1), 32'd1);
        tick(); tick();
        chk1("busyload[3]", exp_instr[3], exp_data[3], 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        chk1("busyload.end", '0, '0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        chk1("busyload.idle", '0, '0, 1'b0, '0, 1'b0, 1'b0);

        // abort beats start in IDLE
        start1 = 1'b1; abort = 1'b1;
        tick();
        start1 = 1'b0; abort = 1'b0;
        chk1("start_abort", '0, '0, 1'b0, '0, 1'b0, 1'b0);

        // start with pause: RUN first, then PAUSE; abort beats pause
        start1 = 1'b1; pause = 1'b1;
        tick();
        start1 = 1'b0;
        chk1("start_pause.run", exp_instr[0], exp_data[0], 1'b1, 4'd0, 1'b1, 1'b0);
        tick();
        chk1("start_pause.pause", exp_instr[0], exp_data[0], 1'b0, 4'd0, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0; pause = 1'b0;
        chk1("abort_pause", '0, '0, 1'b0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
